// File: rtl/cpu_pkg.sv
// Shared RV32IM pipeline definitions: widths, ALU opcodes and operand-select encodings.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int ALU_OPW = 5;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_FWD    = 5'b01000,
    ALU_SUB    = 5'b10000,
    ALU_SRA    = 5'b10101,
    ALU_MUL    = 5'b11000,
    ALU_MULH   = 5'b11001,
    ALU_MULHSU = 5'b11010,
    ALU_MULHU  = 5'b11011,
    ALU_DIV    = 5'b11100,
    ALU_DIVU   = 5'b11101,
    ALU_REM    = 5'b11110,
    ALU_REMU   = 5'b11111
  } alu_op_e;

  typedef enum logic {
    OP1_RS1 = 1'b0,
    OP1_PC  = 1'b1
  } op1_sel_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Per-operand bypass mux: the youngest in-flight producer (EX/MEM) beats MEM/WB; x0 is never bypassed.
module forward_unit #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   value_o
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i);
  assign hit_memwb = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i);

  always_comb begin
    value_o = rf_data_i;
    if (hit_exmem)      value_o = exmem_result_i;
    else if (hit_memwb) value_o = memwb_data_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypassing, ALU operand selection and load-use stall detection.
module id_ex_stage #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int REG_AW  = cpu_pkg::REG_AW,
  parameter int ALU_OPW = cpu_pkg::ALU_OPW
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               HOLD,
  input  logic               FLUSH,
  input  logic               ID_VALID,
  input  logic [XLEN-1:0]    ID_PC,
  input  logic [XLEN-1:0]    ID_RS1_DATA,
  input  logic [XLEN-1:0]    ID_RS2_DATA,
  input  logic [XLEN-1:0]    ID_IMM,
  input  logic [REG_AW-1:0]  ID_RS1_ADDR,
  input  logic [REG_AW-1:0]  ID_RS2_ADDR,
  input  logic [REG_AW-1:0]  ID_RD_ADDR,
  input  logic               ID_USES_RS1,
  input  logic               ID_USES_RS2,
  input  logic               ID_OP1_SEL,
  input  logic               ID_OP2_SEL,
  input  logic [ALU_OPW-1:0] ID_ALU_OP,
  input  logic               ID_MEM_READ,
  input  logic               ID_MEM_WRITE,
  input  logic               ID_REG_WRITE,
  input  logic               EXMEM_REG_WRITE,
  input  logic [REG_AW-1:0]  EXMEM_RD_ADDR,
  input  logic [XLEN-1:0]    EXMEM_RESULT,
  input  logic               MEMWB_REG_WRITE,
  input  logic [REG_AW-1:0]  MEMWB_RD_ADDR,
  input  logic [XLEN-1:0]    MEMWB_DATA,
  output logic [XLEN-1:0]    DATA1,
  output logic [XLEN-1:0]    DATA2,
  output logic [ALU_OPW-1:0] SELECT,
  output logic [XLEN-1:0]    EX_STORE_DATA,
  output logic [XLEN-1:0]    EX_PC,
  output logic [REG_AW-1:0]  EX_RD_ADDR,
  output logic               EX_VALID,
  output logic               EX_MEM_READ,
  output logic               EX_MEM_WRITE,
  output logic               EX_REG_WRITE,
  output logic               STALL
);

  import cpu_pkg::*;

  typedef struct packed {
    logic               valid;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [REG_AW-1:0]  rs1_addr;
    logic [REG_AW-1:0]  rs2_addr;
    logic [REG_AW-1:0]  rd_addr;
    logic               op1_sel;
    logic               op2_sel;
    logic [ALU_OPW-1:0] alu_op;
  } ex_reg_t;

  // The all-zero record is the bubble: no control bits, x0 operands, SELECT = ADD.
  ex_reg_t ex_q, ex_d, id_load;
  logic    stall;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign stall = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && ID_VALID &&
                 ((ID_USES_RS1 && (ID_RS1_ADDR == ex_q.rd_addr)) ||
                  (ID_USES_RS2 && (ID_RS2_ADDR == ex_q.rd_addr)));

  always_comb begin
    id_load           = '0;
    id_load.valid     = ID_VALID;
    id_load.mem_read  = ID_VALID && ID_MEM_READ;
    id_load.mem_write = ID_VALID && ID_MEM_WRITE;
    id_load.reg_write = ID_VALID && ID_REG_WRITE;
    id_load.pc        = ID_PC;
    id_load.rs1_data  = ID_RS1_DATA;
    id_load.rs2_data  = ID_RS2_DATA;
    id_load.imm       = ID_IMM;
    id_load.rs1_addr  = ID_RS1_ADDR;
    id_load.rs2_addr  = ID_RS2_ADDR;
    id_load.rd_addr   = ID_RD_ADDR;
    id_load.op1_sel   = ID_OP1_SEL;
    id_load.op2_sel   = ID_OP2_SEL;
    id_load.alu_op    = ID_ALU_OP;
  end

  always_comb begin
    // NOTE: default to the current value first so the HOLD path never infers a latch.
    ex_d = ex_q;
    if (!HOLD) begin
      if (FLUSH || stall) ex_d = '0;
      else                ex_d = id_load;
    end
  end

  // NOTE: state updates use non-blocking assignment; reset is synchronous and beats HOLD.
  always_ff @(posedge CLK) begin
    if (!RESET) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr_i      (ex_q.rs1_addr),
    .rf_data_i      (ex_q.rs1_data),
    .exmem_we_i     (EXMEM_REG_WRITE),
    .exmem_rd_i     (EXMEM_RD_ADDR),
    .exmem_result_i (EXMEM_RESULT),
    .memwb_we_i     (MEMWB_REG_WRITE),
    .memwb_rd_i     (MEMWB_RD_ADDR),
    .memwb_data_i   (MEMWB_DATA),
    .value_o        (rs1_fwd)
  );

  forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr_i      (ex_q.rs2_addr),
    .rf_data_i      (ex_q.rs2_data),
    .exmem_we_i     (EXMEM_REG_WRITE),
    .exmem_rd_i     (EXMEM_RD_ADDR),
    .exmem_result_i (EXMEM_RESULT),
    .memwb_we_i     (MEMWB_REG_WRITE),
    .memwb_rd_i     (MEMWB_RD_ADDR),
    .memwb_data_i   (MEMWB_DATA),
    .value_o        (rs2_fwd)
  );

  assign DATA1         = (ex_q.op1_sel == OP1_PC)  ? ex_q.pc  : rs1_fwd;
  assign DATA2         = (ex_q.op2_sel == OP2_IMM) ? ex_q.imm : rs2_fwd;
  assign EX_STORE_DATA = rs2_fwd;
  assign SELECT        = ex_q.alu_op;
  assign EX_PC         = ex_q.pc;
  assign EX_RD_ADDR    = ex_q.rd_addr;
  assign EX_VALID      = ex_q.valid;
  assign EX_MEM_READ   = ex_q.mem_read;
  assign EX_MEM_WRITE  = ex_q.mem_write;
  assign EX_REG_WRITE  = ex_q.reg_write;
  assign STALL         = stall;

endmodule
